// File: rtl/ide_swap_ctrl_pkg.sv
// +----------------------------------------------------------------------------+
// | ide_pkg: shared constants, types and helpers for the IDE byte-swap control |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package ide_pkg;

  localparam logic [7:0] CMD_IDENTIFY        = 8'hEC;
  localparam logic [7:0] CMD_IDENTIFY_PACKET = 8'hA1;
  localparam logic [7:0] CMD_SLOT_OFF        = 8'hFF;

  localparam logic [2:0] REG_DATA    = 3'd0;
  localparam logic [2:0] REG_DEVHEAD = 3'd6;
  localparam logic [2:0] REG_CMD     = 3'd7;
  localparam logic [2:0] REG_DEVCTL  = 3'd6;

  // Active-low chip-select patterns: command block on CS0, control block on CS1
  localparam logic [1:0] CS_TASK = 2'b10;
  localparam logic [1:0] CS_CTRL = 2'b01;

  localparam int SRST_BIT = 2;
  localparam int DEV_BIT  = 4;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_STRAIGHT = 1'b1
  } state_e;

  typedef struct packed {
    logic       diow_n;
    logic       dior_n;
    logic [1:0] cs_n;
    logic [2:0] da;
    logic [7:0] dat;
  } bus_t;

  localparam bus_t BUS_IDLE = '{diow_n: 1'b1, dior_n: 1'b1, cs_n: 2'b11, da: 3'd0, dat: 8'h00};

  function automatic logic slot_hit(input logic [7:0] cmd, input logic [7:0] slot);
    return (slot != CMD_SLOT_OFF) && (cmd == slot);
  endfunction

  function automatic logic [15:0] byte_swap16(input logic [15:0] v);
    return {v[7:0], v[15:8]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/ide_swap_ctrl_path.sv
// +----------------------------------------------------------------------------+
// | ide_swap_path: tristate host/drive datapath with optional lane exchange    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module ide_swap_path
  import ide_pkg::*;
(
  input  logic        swap,
  input  logic        dior_n,
  input  logic        diow_n,
  inout  wire  [15:0] host_d,
  inout  wire  [15:0] drv_d
);

  logic [15:0] w_to_host;
  logic [15:0] w_to_drv;

  assign w_to_host = swap ? byte_swap16(drv_d) : drv_d;
  assign w_to_drv  = swap ? byte_swap16(host_d) : host_d;

  assign host_d = !dior_n ? w_to_host : 16'hzzzz;
  assign drv_d  = !diow_n ? w_to_drv  : 16'hzzzz;

endmodule

`default_nettype wire

// File: rtl/ide_swap_ctrl.sv
// +----------------------------------------------------------------------------+
// | ide_swap_ctrl: taskfile snooper deciding byte-swap for IDE data traffic    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module ide_swap_ctrl
  import ide_pkg::*;
#(
  parameter int         WORDS_PER_SECTOR = 256,
  parameter logic [7:0] NOSWAP_CMD0      = CMD_IDENTIFY,
  parameter logic [7:0] NOSWAP_CMD1      = CMD_IDENTIFY_PACKET,
  parameter logic [7:0] NOSWAP_CMD2      = CMD_SLOT_OFF,
  parameter bit         SWAP_DEFAULT     = 1'b1,
  localparam int        CNT_W            = $clog2(WORDS_PER_SECTOR + 1)
) (
  input  logic             CLK,
  input  logic             _RESET,
  inout  wire  [15:0]      D,
  inout  wire  [15:0]      DD,
  input  logic [1:0]       _CS,
  input  logic [2:0]       DA,
  input  logic             _DIOW,
  input  logic             _DIOR,
  output logic             SWAP,
  output logic             STRAIGHT,
  output logic [7:0]       CMD,
  output logic [7:0]       LASTCMD,
  output logic             DEV,
  output logic [CNT_W-1:0] WORD_CNT
);

  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(WORDS_PER_SECTOR);

  bus_t             s1_q, s1_d, s2_q, s2_d, snap_q, snap_d;
  logic [1:0]       hist_q, hist_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       cmd_q, cmd_d, lastcmd_q, lastcmd_d;
  logic             dev_q, dev_d;

  logic w_wr_rise, w_rd_rise, w_task, w_ctrl;
  logic w_cmd_wr, w_dev_wr, w_srst, w_data_edge, w_hit;

  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      s1_q      <= BUS_IDLE;
      s2_q      <= BUS_IDLE;
      snap_q    <= BUS_IDLE;
      hist_q    <= 2'b11;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      cmd_q     <= 8'h00;
      lastcmd_q <= 8'h00;
      dev_q     <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      snap_q    <= snap_d;
      hist_q    <= hist_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmd_q     <= cmd_d;
      lastcmd_q <= lastcmd_d;
      dev_q     <= dev_d;
    end
  end

  // Bus fields ride in the same stage as the strobes, so the snapshot taken
  // on the last low cycle sits inside the host's data-valid window.
  always_comb begin
    s1_d   = {_DIOW, _DIOR, _CS, DA, D[7:0]};
    s2_d   = s1_q;
    hist_d = {s2_q.diow_n, s2_q.dior_n};
    snap_d = snap_q;
    if (!s2_q.diow_n || !s2_q.dior_n) begin
      snap_d = s2_q;
    end
  end

  always_comb begin
    w_wr_rise   = !hist_q[1] && s2_q.diow_n;
    w_rd_rise   = !hist_q[0] && s2_q.dior_n && !w_wr_rise;
    w_task      = (snap_q.cs_n == CS_TASK);
    w_ctrl      = (snap_q.cs_n == CS_CTRL);
    w_cmd_wr    = w_wr_rise && w_task && (snap_q.da == REG_CMD);
    w_dev_wr    = w_wr_rise && w_task && (snap_q.da == REG_DEVHEAD);
    w_srst      = w_wr_rise && w_ctrl && (snap_q.da == REG_DEVCTL) && snap_q.dat[SRST_BIT];
    w_data_edge = (w_wr_rise || w_rd_rise) && w_task && (snap_q.da == REG_DATA);
    w_hit       = slot_hit(snap_q.dat, NOSWAP_CMD0) ||
                  slot_hit(snap_q.dat, NOSWAP_CMD1) ||
                  slot_hit(snap_q.dat, NOSWAP_CMD2);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmd_d     = cmd_q;
    lastcmd_d = lastcmd_q;
    dev_d     = dev_q;

    if (w_cmd_wr) begin
      lastcmd_d = cmd_q;
      cmd_d     = snap_q.dat;
      if (w_hit) begin
        state_d = ST_STRAIGHT;
        cnt_d   = C_FULL;
      end else begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    end else if (w_srst) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (w_data_edge && (state_q == ST_STRAIGHT)) begin
      // The word that empties the counter also ends the straight phase.
      if (cnt_q <= CNT_W'(1)) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end

    if (w_dev_wr) begin
      dev_d = snap_q.dat[DEV_BIT];
    end
  end

  // Raw pins keep SWAP stable for the whole access; STRAIGHT only moves
  // after the strobe has gone high.
  assign SWAP     = SWAP_DEFAULT && (_CS == CS_TASK) && (DA == REG_DATA) &&
                    (state_q != ST_STRAIGHT);
  assign STRAIGHT = (state_q == ST_STRAIGHT);
  assign CMD      = cmd_q;
  assign LASTCMD  = lastcmd_q;
  assign DEV      = dev_q;
  assign WORD_CNT = cnt_q;

  ide_swap_path u_path (
    .swap   (SWAP),
    .dior_n (_DIOR),
    .diow_n (_DIOW),
    .host_d (D),
    .drv_d  (DD)
  );

endmodule

`default_nettype wire
